// File: rtl/mmem_pkg.sv
// Shared defaults, clear-sequencer state encoding and parity helper for the M-memory scratchpad.
package mmem_pkg;

   localparam int MMEM_W        = 32;
   localparam int MMEM_AW       = 5;
   localparam int MMEM_NRD      = 2;
   // Widest data word par_even accepts; narrower words are zero-extended.
   localparam int MMEM_PAR_MAXW = 64;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } mmem_state_e;

   // Even parity bit: makes the total count of ones across data+parity even.
   function automatic logic par_even(input logic [MMEM_PAR_MAXW-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/mmem_clear_seq.sv
// Post-reset clear sweep: walks every word once, writing zero, then parks in RUN until the next reset.
module mmem_clear_seq
   import mmem_pkg::*;
#(
   parameter int AW = MMEM_AW
)
(
   input  logic          clk_i,
   input  logic          rst_i,
   output logic          busy_o,
   output logic          clr_we_o,
   output logic [AW-1:0] clr_adr_o,
   output mmem_state_e   state_o
);

   mmem_state_e   state_q, state_d;
   logic [AW-1:0] ctr_q, ctr_d;

   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      if (state_q == CLEAR) begin
         ctr_d = ctr_q + 1'b1;
         if (ctr_q == '1) state_d = RUN;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= CLEAR;
         ctr_q   <= '0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
      end
   end

   assign busy_o    = (state_q == CLEAR);
   assign clr_we_o  = (state_q == CLEAR);
   assign clr_adr_o = ctr_q;
   assign state_o   = state_q;

endmodule

// File: rtl/mmem_multiport.sv
// NRD-read / 1-write M-memory scratchpad with zeroing sweep and write-first bypass.
// Optional per-word even parity is enabled by defining MMEM_PARITY_EN.
module mmem_multiport
   import mmem_pkg::*;
#(
   parameter int W   = MMEM_W,
   parameter int AW  = MMEM_AW,
   parameter int NRD = MMEM_NRD
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [NRD-1:0]    mrp,
   input  logic [NRD*AW-1:0] madr,
   input  logic              mwp,
   input  logic [AW-1:0]     mwadr,
   input  logic [W-1:0]      l,
   output logic [NRD*W-1:0]  mmem,
   output logic              busy,
   output logic [NRD-1:0]    perr
);

   localparam int DEPTH = 1 << AW;
`ifdef MMEM_PARITY_EN
   localparam int WS = W + 1;
`else
   localparam int WS = W;
`endif

   mmem_state_e   state;
   logic          run;
   logic          clr_we;
   logic [AW-1:0] clr_adr;
   logic          we;
   logic [AW-1:0] wadr;
   logic [W-1:0]  wdata;
   logic [WS-1:0] wword;

   mmem_clear_seq #(.AW(AW)) u_clear_seq (
      .clk_i     (clk),
      .rst_i     (reset),
      .busy_o    (busy),
      .clr_we_o  (clr_we),
      .clr_adr_o (clr_adr),
      .state_o   (state)
   );

   // External writes are only honoured once the sweep has finished.
   assign run   = (state == RUN);
   assign we    = clr_we | (run & mwp);
   assign wadr  = clr_we ? clr_adr : mwadr;
   assign wdata = clr_we ? '0 : l;

`ifdef MMEM_PARITY_EN
   assign wword = {par_even(MMEM_PAR_MAXW'(wdata)), wdata};
`else
   assign wword = wdata;
`endif

   // One replicated bank per read port keeps each bank a plain 1R1W RAM.
   for (genvar g = 0; g < NRD; g++) begin : g_port
      logic [WS-1:0] mem_q [DEPTH];
      logic [AW-1:0] radr;
      logic [WS-1:0] rword;
      logic          hit;
      logic [W-1:0]  rdata_q, rdata_d;

      assign radr  = madr[g*AW +: AW];
      assign rword = mem_q[radr];
      assign hit   = mwp && (radr == mwadr);

      always_ff @(posedge clk) begin
         if (we) mem_q[wadr] <= wword;
      end

      always_comb begin
         rdata_d = rdata_q;
         if (run && mrp[g]) rdata_d = hit ? l : rword[W-1:0];
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) rdata_q <= '0;
         else       rdata_q <= rdata_d;
      end

      assign mmem[g*W +: W] = rdata_q;

`ifdef MMEM_PARITY_EN
      logic perr_q, perr_d;

      // Bypassed data never touched the array, so it cannot carry a parity fault.
      always_comb begin
         perr_d = perr_q;
         if (run && mrp[g]) perr_d = !hit && (^rword);
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) perr_q <= 1'b0;
         else       perr_q <= perr_d;
      end

      assign perr[g] = perr_q;
`else
      assign perr[g] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_mmem_multiport.sv
// Self-checking bench for mmem_multiport: behavioural memory model plus directed vectors.
module tb_mmem_multiport;

   localparam int W     = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;
   localparam int DEPTH = 1 << AW;

   logic              clk;
   logic              reset;
   logic [NRD-1:0]    mrp;
   logic [NRD*AW-1:0] madr;
   logic              mwp;
   logic [AW-1:0]     mwadr;
   logic [W-1:0]      l;
   logic [NRD*W-1:0]  mmem;
   logic              busy;
   logic [NRD-1:0]    perr;

   int n_cmp;
   int n_bad;
   logic chk_en;

   mmem_multiport #(.W(W), .AW(AW), .NRD(NRD)) dut (
      .clk   (clk),
      .reset (reset),
      .mrp   (mrp),
      .madr  (madr),
      .mwp   (mwp),
      .mwadr (mwadr),
      .l     (l),
      .mmem  (mmem),
      .busy  (busy),
      .perr  (perr)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [W-1:0]   m_mem [DEPTH];
   logic           m_bad [DEPTH];
   logic [W-1:0]   exp_mmem [NRD];
   logic [NRD-1:0] exp_perr;
   int             sweep_left;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sweep_left = DEPTH;
         for (int a = 0; a < DEPTH; a++) begin
            m_mem[a] = '0;
            m_bad[a] = 1'b0;
         end
         for (int i = 0; i < NRD; i++) exp_mmem[i] = '0;
         exp_perr = '0;
      end else if (sweep_left != 0) begin
         sweep_left = sweep_left - 1;
      end else begin
         for (int i = 0; i < NRD; i++) begin
            if (mrp[i]) begin
               logic [AW-1:0] a;
               a = madr[i*AW +: AW];
               if (mwp && a == mwadr) begin
                  exp_mmem[i] = l;
                  exp_perr[i] = 1'b0;
               end else begin
                  exp_mmem[i] = m_mem[a];
                  exp_perr[i] = m_bad[a];
               end
            end
         end
         if (mwp) begin
            m_mem[mwadr] = l;
            m_bad[mwadr] = 1'b0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && chk_en) begin
         check("busy", W'(busy), W'(sweep_left != 0));
         for (int i = 0; i < NRD; i++) begin
            check($sformatf("mmem[%0d]", i), mmem[i*W +: W], exp_mmem[i]);
            check($sformatf("perr[%0d]", i), W'(perr[i]), W'(exp_perr[i]));
         end
      end
   end

   // ---------------- driver ----------------
   // Drive one vector at a negedge, let one rising edge consume it, return at the next negedge.
   task automatic cycle(input logic [NRD-1:0] rp, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic wp, input logic [AW-1:0] wa, input logic [W-1:0] wd);
      mrp   = rp;
      madr  = {a1, a0};
      mwp   = wp;
      mwadr = wa;
      l     = wd;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      cycle(2'b00, '0, '0, 1'b0, '0, '0);
   endtask

   int cnt;

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      chk_en = 1'b1;
      reset  = 1'b1;
      mrp    = '0;
      madr   = '0;
      mwp    = 1'b0;
      mwadr  = '0;
      l      = '0;
      repeat (3) @(negedge clk);

      // Reset release: busy high exactly DEPTH edges; an ignored write lands at sweep edge 10.
      reset = 1'b0;
      check("busy_after_reset", W'(busy), 32'd1);
      check("mmem0_after_reset", mmem[0 +: W], 32'd0);
      cnt = 0;
      mrp = 2'b11;
      madr = {5'd20, 5'd3};
      while (busy && cnt < 100) begin
         if (cnt == 9) begin
            mwp = 1'b1; mwadr = 5'd20; l = 32'h0000FFFF;
         end else begin
            mwp = 1'b0;
         end
         @(posedge clk);
         #1;
         cnt++;
      end
      mwp = 1'b0;
      mrp = '0;
      check("sweep_len", W'(cnt), 32'd32);
      @(negedge clk);

      // Every address on both ports reads zero after the sweep.
      for (int a = 0; a < DEPTH; a++) begin
         cycle(2'b11, AW'(a), AW'(DEPTH - 1 - a), 1'b0, '0, '0);
         if (a == 20) check("drop_write_during_sweep", mmem[0 +: W], 32'd0);
      end

      // Write then read back, then hold with mrp low.
      cycle(2'b00, '0, '0, 1'b1, 5'd7, 32'hDEADBEEF);
      cycle(2'b01, 5'd7, '0, 1'b0, '0, '0);
      check("readback_7", mmem[0 +: W], 32'hDEADBEEF);
      cycle(2'b00, 5'd1, 5'd2, 1'b0, '0, '0);
      check("hold_7", mmem[0 +: W], 32'hDEADBEEF);

      // Same-edge collision: port0 bypasses, port1 sees the prior word at 4.
      cycle(2'b00, '0, '0, 1'b1, 5'd4, 32'hA5A50004);
      cycle(2'b11, 5'd3, 5'd4, 1'b1, 5'd3, 32'h12345678);
      check("bypass_p0", mmem[0 +: W], 32'h12345678);
      check("nobypass_p1", mmem[W +: W], 32'hA5A50004);

      // Both ports on one address, then a bypass on port1 only.
      cycle(2'b11, 5'd7, 5'd7, 1'b0, '0, '0);
      check("same_addr_p1", mmem[W +: W], 32'hDEADBEEF);
      cycle(2'b11, 5'd7, 5'd9, 1'b1, 5'd9, 32'h0BADF00D);
      check("bypass_p1", mmem[W +: W], 32'h0BADF00D);

      // Directed sweep of writes/reads with offset collisions.
      for (int i = 0; i < 16; i++) begin
         cycle(2'b11, AW'(2 * i), AW'(i), 1'b1, AW'(2 * i), 32'hC0DE0000 | W'(i));
      end
      for (int i = 0; i < 16; i++) begin
         cycle(2'b11, AW'(i), AW'(31 - i), (i % 3) == 0, AW'(31 - i), 32'h5EED0000 | W'(i));
      end

`ifdef MMEM_PARITY_EN
      // Corrupt one stored data bit of word 9 in every bank.
      cycle(2'b00, '0, '0, 1'b1, 5'd9, 32'h00000001);
      dut.g_port[0].mem_q[9][0] = ~dut.g_port[0].mem_q[9][0];
      dut.g_port[1].mem_q[9][0] = ~dut.g_port[1].mem_q[9][0];
      m_mem[9] = m_mem[9] ^ 32'h1;
      m_bad[9] = 1'b1;
      cycle(2'b01, 5'd9, '0, 1'b0, '0, '0);
      check("perr_set", W'(perr[0]), 32'd1);
      cycle(2'b01, 5'd7, '0, 1'b0, '0, '0);
      check("perr_clear", W'(perr[0]), 32'd0);
`else
      cycle(2'b11, 5'd9, 5'd7, 1'b0, '0, '0);
      check("perr_tied", W'(perr), 32'd0);
`endif

      // Reset pulsed at sweep edge 15 restarts the full sweep.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mrp = 2'b11;
      madr = {5'd7, 5'd4};
      repeat (15) @(negedge clk);
      check("busy_mid_sweep", W'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("mmem1_in_reset", mmem[W +: W], 32'd0);
      reset = 1'b0;
      cnt = 0;
      while (busy && cnt < 100) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check("sweep_restart_len", W'(cnt), 32'd32);
      @(negedge clk);
      mrp = '0;
      check("mmem0_after_restart", mmem[0 +: W], 32'd0);
      cycle(2'b11, 5'd7, 5'd4, 1'b0, '0, '0);
      check("cleared_7", mmem[0 +: W], 32'd0);
      idle();

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
